// File: rtl/cache_refill_memory.sv
// cache_refill_memory: backing word-addressed main memory that responds to
// the data cache's refill and write-through traffic.
//
// Ports:
//   clk, rst        - clock, asynchronous active-low reset
//   req_valid/ready - request handshake (cache is the initiator)
//   req_write       - 1 = write, 0 = block read
//   req_addr        - byte address
//   req_wdata       - write data, right-aligned for sub-word stores
//   req_storetype   - 00 word, 01 halfword, 10 byte, 11 word
//   rsp_valid       - response beat valid (no backpressure)
//   rsp_data        - read beat data, 0 on write ack and when idle
//   rsp_last        - final beat of a response
//
// A read is answered after LATENCY wait cycles with BLOCK_WORDS consecutive
// beats in ascending word order. A write commits to storage on the same edge
// that raises its single ack beat, so a following read sees the new data.
module cache_refill_memory #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned BLOCK_WORDS = 4,
    parameter int unsigned LATENCY     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [1:0]        req_storetype,
    output logic              rsp_valid,
    output logic [31:0]       rsp_data,
    output logic              rsp_last
);

    localparam int unsigned WIDX_W = ADDR_W - 2;
    localparam int unsigned DEPTH  = 1 << WIDX_W;
    localparam int unsigned BEAT_W = $clog2(BLOCK_WORDS);
    localparam int unsigned CNT_W  = $clog2(LATENCY + 1);

    localparam logic [1:0] ST_HALF = 2'b01;
    localparam logic [1:0] ST_BYTE = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2,
        WACK  = 2'd3
    } state_t;

    // Storage; deliberately outside the reset domain.
    logic [31:0] mem [DEPTH];

    state_t              state_q,     state_d;
    logic [CNT_W-1:0]    cnt_q,       cnt_d;
    logic [BEAT_W-1:0]   beat_q,      beat_d;
    logic                write_q,     write_d;
    logic [ADDR_W-1:0]   addr_q,      addr_d;
    logic [31:0]         wdata_q,     wdata_d;
    logic [1:0]          stype_q,     stype_d;
    logic                req_ready_q, req_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [31:0]         rsp_data_q,  rsp_data_d;
    logic                rsp_last_q,  rsp_last_d;

    logic [WIDX_W-1:0]        word_idx_c;
    logic [WIDX_W-BEAT_W-1:0] blk_idx_c;
    logic [BEAT_W-1:0]        next_beat_c;
    logic [WIDX_W-1:0]        rd_idx_c;
    logic [31:0]              rd_word_c;
    logic [31:0]              mem_wdata_c;
    logic                     mem_we_c;

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_last  = rsp_last_q;

    // Address decode for the latched request; the burst index wraps inside
    // the block whose low word bits are cleared.
    always_comb begin
        word_idx_c  = addr_q[ADDR_W-1:2];
        blk_idx_c   = addr_q[ADDR_W-1:2+BEAT_W];
        next_beat_c = (state_q == BURST) ? BEAT_W'(beat_q + BEAT_W'(1)) : '0;
        rd_idx_c    = {blk_idx_c, next_beat_c};
        rd_word_c   = mem[rd_idx_c];
    end

    // Byte-lane merge of the latched store into the current word.
    always_comb begin
        mem_wdata_c = mem[word_idx_c];
        case (stype_q)
            ST_HALF: begin
                if (addr_q[1]) begin
                    mem_wdata_c[31:16] = wdata_q[15:0];
                end else begin
                    mem_wdata_c[15:0] = wdata_q[15:0];
                end
            end
            ST_BYTE: mem_wdata_c[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            default: mem_wdata_c = wdata_q;
        endcase
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        beat_d      = beat_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        stype_d     = stype_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = 32'h0;
        rsp_last_d  = 1'b0;
        mem_we_c    = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid) begin
                    write_d     = req_write;
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    stype_d     = req_storetype;
                    cnt_d       = CNT_W'(LATENCY);
                    req_ready_d = 1'b0;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    rsp_valid_d = 1'b1;
                    if (write_q) begin
                        // Commit on the same edge the ack is raised.
                        mem_we_c   = 1'b1;
                        rsp_last_d = 1'b1;
                        state_d    = WACK;
                    end else begin
                        beat_d     = '0;
                        rsp_data_d = rd_word_c;
                        state_d    = BURST;
                    end
                end
            end
            BURST: begin
                if (rsp_last_q) begin
                    req_ready_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    beat_d      = next_beat_c;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = rd_word_c;
                    rsp_last_d  = (next_beat_c == {BEAT_W{1'b1}});
                end
            end
            WACK: begin
                req_ready_d = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                req_ready_d = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            beat_q      <= '0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= 32'h0;
            stype_q     <= 2'b00;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 32'h0;
            rsp_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            beat_q      <= beat_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            stype_q     <= stype_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_last_q  <= rsp_last_d;
        end
    end

    // Storage write port.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem[word_idx_c] <= mem_wdata_c;
        end
    end

endmodule

// File: tb/tb_cache_refill_memory.sv
// Directed bench for cache_refill_memory: inputs driven and outputs sampled
// on the falling edge; every expected value is written out by hand.
module tb_cache_refill_memory;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned BW     = 4;
    localparam int unsigned LAT    = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_write = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [31:0]       req_wdata = 32'h0;
    logic [1:0]        req_storetype = 2'b00;
    logic              rsp_valid;
    logic [31:0]       rsp_data;
    logic              rsp_last;

    int checks = 0;
    int errors = 0;

    cache_refill_memory #(
        .ADDR_W      (ADDR_W),
        .BLOCK_WORDS (BW),
        .LATENCY     (LAT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_write     (req_write),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_storetype (req_storetype),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .rsp_last      (rsp_last)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] blk4(input logic [31:0] e0, input logic [31:0] e1,
                                          input logic [31:0] e2, input logic [31:0] e3);
        return {e3, e2, e1, e0};
    endfunction

    // Present a request at the current falling edge; the next rising edge accepts it.
    task automatic start_req(input string tag, input logic w, input logic [ADDR_W-1:0] a,
                             input logic [31:0] d, input logic [1:0] st);
        chk({tag, ".acc_ready"}, 32'(req_ready), 32'd1);
        req_valid     = 1'b1;
        req_write     = w;
        req_addr      = a;
        req_wdata     = d;
        req_storetype = st;
    endtask

    // Scramble request fields after acceptance; they must have no effect.
    task automatic scramble();
        req_valid     = 1'b0;
        req_write     = 1'b1;
        req_addr      = '1;
        req_wdata     = 32'hFFFF_FFFF;
        req_storetype = 2'b10;
    endtask

    task automatic finish_read(input string tag, input logic [127:0] exp, input bit hold,
                               input logic [ADDR_W-1:0] next_addr);
        for (int k = 1; k <= int'(LAT); k++) begin
            @(negedge clk);
            if (k == 1) begin
                if (hold) begin
                    req_addr = next_addr;
                end else begin
                    scramble();
                end
            end
            chk($sformatf("%s.wait%0d_ready", tag, k), 32'(req_ready), 32'd0);
            chk($sformatf("%s.wait%0d_valid", tag, k), 32'(rsp_valid), 32'd0);
        end
        for (int b = 0; b < int'(BW); b++) begin
            @(negedge clk);
            chk($sformatf("%s.beat%0d_valid", tag, b), 32'(rsp_valid), 32'd1);
            chk($sformatf("%s.beat%0d_data", tag, b), rsp_data, exp[32*b +: 32]);
            chk($sformatf("%s.beat%0d_last", tag, b), 32'(rsp_last),
                (b == int'(BW) - 1) ? 32'd1 : 32'd0);
            chk($sformatf("%s.beat%0d_ready", tag, b), 32'(req_ready), 32'd0);
        end
        @(negedge clk);
        chk({tag, ".end_ready"}, 32'(req_ready), 32'd1);
        chk({tag, ".end_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, ".end_data"}, rsp_data, 32'h0);
    endtask

    task automatic finish_write(input string tag);
        for (int k = 1; k <= int'(LAT); k++) begin
            @(negedge clk);
            if (k == 1) scramble();
            chk($sformatf("%s.wait%0d_ready", tag, k), 32'(req_ready), 32'd0);
            chk($sformatf("%s.wait%0d_valid", tag, k), 32'(rsp_valid), 32'd0);
        end
        @(negedge clk);
        chk({tag, ".ack_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, ".ack_last"}, 32'(rsp_last), 32'd1);
        chk({tag, ".ack_data"}, rsp_data, 32'h0);
        chk({tag, ".ack_ready"}, 32'(req_ready), 32'd0);
        @(negedge clk);
        chk({tag, ".end_ready"}, 32'(req_ready), 32'd1);
        chk({tag, ".end_valid"}, 32'(rsp_valid), 32'd0);
    endtask

    task automatic do_write(input string tag, input logic [ADDR_W-1:0] a,
                            input logic [31:0] d, input logic [1:0] st);
        start_req(tag, 1'b1, a, d, st);
        finish_write(tag);
    endtask

    task automatic do_read(input string tag, input logic [ADDR_W-1:0] a, input logic [127:0] exp);
        start_req(tag, 1'b0, a, 32'h0, 2'b00);
        finish_read(tag, exp, 1'b0, '0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".ready"}, 32'(req_ready), 32'd1);
        chk({tag, ".valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, ".data"}, rsp_data, 32'h0);
        chk({tag, ".last"}, 32'(rsp_last), 32'd0);
    endtask

    initial begin
        // Reset state.
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b1;

        // Preload blocks 1 (words 4..7), 2 (words 8..11) and 63 (words 252..255).
        do_write("pre_w4", 10'h010, 32'h4040_4040, 2'b00);
        do_write("pre_w5", 10'h014, 32'h1122_3344, 2'b00);
        do_write("pre_w6", 10'h018, 32'h0000_0066, 2'b00);
        do_write("pre_w7_st11", 10'h01F, 32'h0000_0077, 2'b11);
        do_write("pre_w8", 10'h020, 32'h0000_00A0, 2'b00);
        do_write("pre_w9", 10'h024, 32'h0000_00A1, 2'b00);
        do_write("pre_w10", 10'h028, 32'h0000_00A2, 2'b00);
        do_write("pre_w11", 10'h02C, 32'h0000_00A3, 2'b00);
        do_write("pre_w252", 10'h3F0, 32'h0000_0252, 2'b00);
        do_write("pre_w253", 10'h3F4, 32'h0000_0253, 2'b00);
        do_write("pre_w254", 10'h3F8, 32'h0000_0254, 2'b00);

        // Block read from a mid-block address starts at the block base.
        do_read("rd_blk2", 10'h024, blk4(32'hA0, 32'hA1, 32'hA2, 32'hA3));
        do_read("rd_blk1", 10'h010, blk4(32'h4040_4040, 32'h1122_3344, 32'h66, 32'h77));

        // Byte store to byte 2 of word 5; upper wdata bits must be ignored.
        do_write("wr_byte", 10'h016, 32'hFFFF_FFEE, 2'b10);
        do_read("rd_after_byte", 10'h01C, blk4(32'h4040_4040, 32'h11EE_3344, 32'h66, 32'h77));

        // Halfword store to the low half of word 5.
        do_write("wr_half", 10'h014, 32'h1234_BEEF, 2'b01);
        do_read("rd_after_half", 10'h014, blk4(32'h4040_4040, 32'h11EE_BEEF, 32'h66, 32'h77));

        // Halfword store to the upper half of word 6, byte store to byte 0 of word 7.
        do_write("wr_half_hi", 10'h01A, 32'h0000_CAFE, 2'b01);
        do_write("wr_byte0", 10'h01C, 32'h0000_0055, 2'b10);
        do_read("rd_hi_lanes", 10'h018, blk4(32'h4040_4040, 32'h11EE_BEEF, 32'hCAFE_0066, 32'h55));

        // Last word of memory, then read its block.
        do_write("wr_last", 10'h3FC, 32'hDEAD_BEEF, 2'b00);
        do_read("rd_last_blk", 10'h3FC, blk4(32'h252, 32'h253, 32'h254, 32'hDEAD_BEEF));

        // Second request held through a whole read; accepted on the first ready cycle.
        start_req("held_first", 1'b0, 10'h020, 32'h0, 2'b00);
        finish_read("held_first", blk4(32'hA0, 32'hA1, 32'hA2, 32'hA3), 1'b1, 10'h010);
        start_req("held_second", 1'b0, 10'h010, 32'h0, 2'b00);
        finish_read("held_second", blk4(32'h4040_4040, 32'h11EE_BEEF, 32'hCAFE_0066, 32'h55),
                    1'b0, '0);

        // Reset during the wait of a write, before its commit edge.
        start_req("rst_wr", 1'b1, 10'h014, 32'hCAFE_F00D, 2'b00);
        @(negedge clk);
        scramble();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_reset_outputs("rst_wr_async");
        @(negedge clk);
        chk_reset_outputs("rst_wr_held");
        @(negedge clk);
        chk_reset_outputs("rst_wr_held2");
        rst = 1'b1;
        @(negedge clk);
        chk_reset_outputs("rst_wr_released");
        do_read("rst_wr_check", 10'h014, blk4(32'h4040_4040, 32'h11EE_BEEF, 32'hCAFE_0066, 32'h55));

        // Reset during beat 2 of a burst.
        start_req("rst_rd", 1'b0, 10'h020, 32'h0, 2'b00);
        for (int k = 1; k <= int'(LAT); k++) begin
            @(negedge clk);
            if (k == 1) scramble();
        end
        @(negedge clk);
        chk("rst_rd.beat0", rsp_data, 32'hA0);
        @(negedge clk);
        chk("rst_rd.beat1", rsp_data, 32'hA1);
        @(negedge clk);
        chk("rst_rd.beat2_valid", 32'(rsp_valid), 32'd1);
        rst = 1'b0;
        #1;
        chk_reset_outputs("rst_rd_async");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("rst_rd.held%0d_valid", k), 32'(rsp_valid), 32'd0);
        end
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("rst_rd.post%0d_valid", k), 32'(rsp_valid), 32'd0);
            chk($sformatf("rst_rd.post%0d_ready", k), 32'(req_ready), 32'd1);
        end
        do_read("rst_rd_recover", 10'h02C, blk4(32'hA0, 32'hA1, 32'hA2, 32'hA3));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
